// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types, default parameter values and helper function
// for the divided-clock period monitor.
//   state_e          : measurement FSM states (IDLE, MEAS)
//   *_DEF constants  : default values of the clk_div_monitor parameters
//   exceeds_tol()    : absolute-deviation-above-tolerance test
package clk_div_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int EXPECT_DIV_DEF  = 10;
  localparam int TOL_DEF         = 0;
  localparam int LOCK_N_DEF      = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  // True when |meas - exp_val| > tol; operands are unsigned cycle counts.
  function automatic logic exceeds_tol(input logic [31:0] meas,
                                       input logic [31:0] exp_val,
                                       input logic [31:0] tol);
    logic [31:0] diff;
    diff = 32'd0;
    if (meas >= exp_val) begin
      diff = meas - exp_val;
    end else begin
      diff = exp_val - meas;
    end
    return (diff > tol);
  endfunction

endpackage

// File: rtl/clk_div_monitor_edge_det.sv
// edge_det: one-flop delay of the monitored signal plus rising-edge detect.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset (clears the delay flop)
//   din   in  signal under test, already synchronous to clk
//   rise  out combinational, high in the cycle din is 1 and was 0 before
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic d1_d;
  logic d1_q;

  // Next value of the delay flop.
  always_comb begin
    d1_d = din;
  end

  // Delay flop with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
    end
  end

  assign rise = din & ~d1_q;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period, high time and low time of a divided
// clock that is synchronous to clk, compares the period with an expected
// value, tracks lock and flags silence.
// Ports:
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   clk_div_in in  divided clock under test (no synchronizer)
//   period     out last measured period (high_time + low_time, saturating)
//   high_time  out cycles sampled high in the last period
//   low_time   out cycles sampled low in the last period
//   meas_valid out one-cycle pulse when the three measurements update
//   locked     out level, LOCK_N consecutive matching periods seen
//   mismatch   out one-cycle pulse with meas_valid when the period is off
//   timeout    out one-cycle pulse after TIMEOUT_CYC cycles without a rise
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EXPECT_DIV  = EXPECT_DIV_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int LOCK_N      = LOCK_N_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  // Silence and match counters are sized from their limits, not CNT_W,
  // so a narrow CNT_W cannot make the timeout unreachable.
  localparam int SIL_W = $clog2(TIMEOUT_CYC + 1);
  localparam int MCH_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SIL_W-1:0] SIL_ONE   = SIL_W'(1);
  localparam logic [SIL_W-1:0] SIL_LIMIT = SIL_W'(TIMEOUT_CYC);
  localparam logic [MCH_W-1:0] MCH_ONE   = MCH_W'(1);
  localparam logic [MCH_W-1:0] MCH_FULL  = MCH_W'(LOCK_N);

  logic rise_s;

  state_e           state_d,  state_q;
  logic [CNT_W-1:0] hi_cnt_d, hi_cnt_q;
  logic [CNT_W-1:0] lo_cnt_d, lo_cnt_q;
  logic [SIL_W-1:0] sil_cnt_d, sil_cnt_q;
  logic [MCH_W-1:0] match_cnt_d, match_cnt_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_time_d, high_time_q;
  logic [CNT_W-1:0] low_time_d, low_time_q;
  logic             meas_valid_d, meas_valid_q;
  logic             mismatch_d, mismatch_q;
  logic             timeout_d, timeout_q;
  logic             locked_d, locked_q;

  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] per_sat_s;
  logic             off_s;
  logic [SIL_W-1:0] sil_inc_s;

  edge_det u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clk_div_in),
    .rise  (rise_s)
  );

  // Saturating period of the counts in progress and its tolerance check.
  always_comb begin
    sum_s = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
    if (sum_s[CNT_W]) begin
      per_sat_s = CNT_MAX;
    end else begin
      per_sat_s = sum_s[CNT_W-1:0];
    end
    off_s     = exceeds_tol(32'(per_sat_s), 32'(EXPECT_DIV), 32'(TOL));
    sil_inc_s = sil_cnt_q + SIL_ONE;
  end

  // FSM next state, counters, measurement capture, lock and timeout.
  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    sil_cnt_d    = sil_cnt_q;
    match_cnt_d  = match_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    low_time_d   = low_time_q;
    meas_valid_d = 1'b0;
    mismatch_d   = 1'b0;
    timeout_d    = 1'b0;
    locked_d     = locked_q;

    if (rise_s) begin
      sil_cnt_d = '0;
    end else begin
      sil_cnt_d = sil_inc_s;
    end

    case (state_q)
      IDLE: begin
        // Anything before the first rise is a partial period: drop it.
        if (rise_s) begin
          state_d  = MEAS;
          hi_cnt_d = CNT_ONE;
          lo_cnt_d = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      MEAS: begin
        if (rise_s) begin
          high_time_d  = hi_cnt_q;
          low_time_d   = lo_cnt_q;
          period_d     = per_sat_s;
          meas_valid_d = 1'b1;
          hi_cnt_d     = CNT_ONE;
          lo_cnt_d     = '0;
          if (off_s) begin
            mismatch_d  = 1'b1;
            match_cnt_d = '0;
            locked_d    = 1'b0;
          end else begin
            if (match_cnt_q != MCH_FULL) begin
              match_cnt_d = match_cnt_q + MCH_ONE;
            end else begin
              match_cnt_d = match_cnt_q;
            end
            locked_d = (match_cnt_d == MCH_FULL);
          end
        end else if (clk_div_in) begin
          if (hi_cnt_q != CNT_MAX) begin
            hi_cnt_d = hi_cnt_q + CNT_ONE;
          end else begin
            hi_cnt_d = hi_cnt_q;
          end
        end else begin
          if (lo_cnt_q != CNT_MAX) begin
            lo_cnt_d = lo_cnt_q + CNT_ONE;
          end else begin
            lo_cnt_d = lo_cnt_q;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        hi_cnt_d = '0;
        lo_cnt_d = '0;
      end
    endcase

    // Silence limit reached; a rise in the same cycle takes precedence.
    if (!rise_s && (sil_inc_s == SIL_LIMIT)) begin
      timeout_d   = 1'b1;
      sil_cnt_d   = '0;
      state_d     = IDLE;
      hi_cnt_d    = '0;
      lo_cnt_d    = '0;
      match_cnt_d = '0;
      locked_d    = 1'b0;
    end else begin
      timeout_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      sil_cnt_q    <= '0;
      match_cnt_q  <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      low_time_q   <= '0;
      meas_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      sil_cnt_q    <= sil_cnt_d;
      match_cnt_q  <= match_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      low_time_q   <= low_time_d;
      meas_valid_q <= meas_valid_d;
      mismatch_q   <= mismatch_d;
      timeout_q    <= timeout_d;
      locked_q     <= locked_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign low_time   = low_time_q;
  assign meas_valid = meas_valid_q;
  assign mismatch   = mismatch_q;
  assign timeout    = timeout_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed bench for clk_div_monitor. Three instances:
//   d0 default parameters, d1 TOL=2, d2 CNT_W=4. Each one is held in reset
//   until its turn. Expected measurements are queued before each driven
//   period and popped by a monitor whenever a meas_valid pulse appears.
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic [2:0] rst_n_v = 3'b000;
  logic [2:0] din_v = 3'b000;

  logic [15:0] per0, hi0, lo0, per1, hi1, lo1;
  logic [3:0]  per2, hi2, lo2;
  wire  [2:0]  mv_v, lk_v, mm_v, to_v;

  logic [15:0] per_a [3];
  logic [15:0] hi_a  [3];
  logic [15:0] lo_a  [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mv_cnt [3] = '{0, 0, 0};
  int to_cnt [3] = '{0, 0, 0};
  int to_cyc [3] = '{0, 0, 0};

  typedef struct {
    int id;
    int per;
    int hi;
    int lo;
    int mm;
    int lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  clk_div_monitor u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .clk_div_in(din_v[0]),
    .period(per0), .high_time(hi0), .low_time(lo0),
    .meas_valid(mv_v[0]), .locked(lk_v[0]), .mismatch(mm_v[0]), .timeout(to_v[0])
  );

  clk_div_monitor #(.TOL(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .clk_div_in(din_v[1]),
    .period(per1), .high_time(hi1), .low_time(lo1),
    .meas_valid(mv_v[1]), .locked(lk_v[1]), .mismatch(mm_v[1]), .timeout(to_v[1])
  );

  clk_div_monitor #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n_v[2]), .clk_div_in(din_v[2]),
    .period(per2), .high_time(hi2), .low_time(lo2),
    .meas_valid(mv_v[2]), .locked(lk_v[2]), .mismatch(mm_v[2]), .timeout(to_v[2])
  );

  // 20 ns clock, first rising edge at 10 ns.
  always #10 clk = ~clk;

  // Rising-edge counter used to time timeout pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Uniform 16-bit views of the instance outputs.
  always_comb begin
    per_a[0] = per0;          hi_a[0] = hi0;          lo_a[0] = lo0;
    per_a[1] = per1;          hi_a[1] = hi1;          lo_a[1] = lo1;
    per_a[2] = {12'd0, per2}; hi_a[2] = {12'd0, hi2}; lo_a[2] = {12'd0, lo2};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  // Monitor: every meas_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (mv_v[d]) begin
        mv_cnt[d]++;
        check_val($sformatf("d%0d_mv_expected", d), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val($sformatf("d%0d_mv_owner", d), 32'(d), 32'(mon_e.id));
          check_val($sformatf("d%0d_period", d), 32'(per_a[d]), 32'(mon_e.per));
          check_val($sformatf("d%0d_high_time", d), 32'(hi_a[d]), 32'(mon_e.hi));
          check_val($sformatf("d%0d_low_time", d), 32'(lo_a[d]), 32'(mon_e.lo));
          check_val($sformatf("d%0d_mismatch", d), 32'(mm_v[d]), 32'(mon_e.mm));
          check_val($sformatf("d%0d_locked", d), 32'(lk_v[d]), 32'(mon_e.lk));
        end
      end
      if (mm_v[d] && !mv_v[d]) begin
        check_val($sformatf("d%0d_mismatch_alone", d), 32'(mm_v[d]), 32'd0);
      end
      if (to_v[d]) begin
        to_cnt[d]++;
        if (to_cnt[d] <= 3) to_cyc[to_cnt[d] - 1] = cyc;
      end
    end
  end

  // Hold din of instance d at v for n clock cycles.
  task automatic drive(input int d, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_v[d] = v;
    end
  endtask

  // One period of h high then l low cycles; queue what its report must show.
  task automatic wave(input int d, input int h, input int l, input int e_per,
                      input int e_hi, input int e_lo, input int e_mm, input int e_lk);
    exp_t e;
    e.id = d; e.per = e_per; e.hi = e_hi; e.lo = e_lo; e.mm = e_mm; e.lk = e_lk;
    exp_q.push_back(e);
    drive(d, 1'b1, h);
    drive(d, 1'b0, l);
  endtask

  task automatic check_zero(input int d, input string tag);
    check_val({tag, "_period"}, 32'(per_a[d]), 32'd0);
    check_val({tag, "_high_time"}, 32'(hi_a[d]), 32'd0);
    check_val({tag, "_low_time"}, 32'(lo_a[d]), 32'd0);
    check_val({tag, "_meas_valid"}, 32'(mv_v[d]), 32'd0);
    check_val({tag, "_locked"}, 32'(lk_v[d]), 32'd0);
    check_val({tag, "_mismatch"}, 32'(mm_v[d]), 32'd0);
    check_val({tag, "_timeout"}, 32'(to_v[d]), 32'd0);
  endtask

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap_mv;
    int rise_c;

    repeat (3) @(negedge clk);
    check_zero(0, "reset");

    // d1 (TOL=2): deviation equal to TOL is still a match; 13 is off.
    rst_n_v[1] = 1'b1;
    wave(1, 5, 4, 9, 5, 4, 0, 0);
    wave(1, 5, 6, 11, 5, 6, 0, 0);
    wave(1, 6, 6, 12, 6, 6, 0, 0);
    wave(1, 5, 5, 10, 5, 5, 0, 1);
    wave(1, 5, 5, 10, 5, 5, 0, 1);
    wave(1, 5, 5, 10, 5, 5, 0, 1);
    wave(1, 7, 6, 13, 7, 6, 1, 0);
    drive(1, 1'b1, 1);
    drive(1, 1'b0, 3);
    check_val("d1_mv_count", 32'(mv_cnt[1]), 32'd7);
    rst_n_v[1] = 1'b0;

    // d2 (CNT_W=4): 20-cycle high phase saturates high_time and period.
    rst_n_v[2] = 1'b1;
    wave(2, 5, 5, 10, 5, 5, 0, 0);
    wave(2, 20, 5, 15, 15, 5, 1, 0);
    drive(2, 1'b1, 1);
    drive(2, 1'b0, 3);
    check_val("d2_mv_count", 32'(mv_cnt[2]), 32'd2);
    rst_n_v[2] = 1'b0;

    // d0: lock on the 4th good period.
    rst_n_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) wave(0, 5, 5, 10, 5, 5, 0, (i >= 3) ? 1 : 0);
    // Stretched high phase breaks lock, then relock after 4 good periods.
    wave(0, 7, 5, 12, 7, 5, 1, 0);
    for (int i = 0; i < 4; i++) wave(0, 5, 5, 10, 5, 5, 0, (i == 3) ? 1 : 0);

    // Last rise, then 200 low cycles: timeouts 64, 128, 192 after the rise.
    @(negedge clk);
    din_v[0] = 1'b1;
    rise_c = cyc + 1;
    drive(0, 1'b1, 4);
    check_val("d0_locked_before_silence", 32'(lk_v[0]), 32'd1);
    snap_mv = mv_cnt[0];
    drive(0, 1'b0, 200);
    check_val("d0_timeout_count", 32'(to_cnt[0]), 32'd3);
    check_val("d0_timeout_1_cycle", 32'(to_cyc[0] - rise_c), 32'd64);
    check_val("d0_timeout_2_cycle", 32'(to_cyc[1] - rise_c), 32'd128);
    check_val("d0_timeout_3_cycle", 32'(to_cyc[2] - rise_c), 32'd192);
    check_val("d0_locked_after_timeout", 32'(lk_v[0]), 32'd0);
    check_val("d0_no_mv_in_silence", 32'(mv_cnt[0] - snap_mv), 32'd0);

    // Restart: the first report needs the second rise and is a full period.
    wave(0, 5, 5, 10, 5, 5, 0, 0);
    wave(0, 5, 5, 10, 5, 5, 0, 0);
    drive(0, 1'b1, 5);
    drive(0, 1'b0, 2);
    check_val("d0_mv_after_restart", 32'(mv_cnt[0] - snap_mv), 32'd2);

    // One-cycle reset in the low phase discards the period in progress.
    @(negedge clk);
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    check_zero(0, "midrst");
    rst_n_v[0] = 1'b1;
    snap_mv = mv_cnt[0];
    drive(0, 1'b0, 3);
    check_val("d0_no_mv_after_reset", 32'(mv_cnt[0] - snap_mv), 32'd0);
    wave(0, 5, 5, 10, 5, 5, 0, 0);
    wave(0, 5, 5, 10, 5, 5, 0, 0);
    // Rise lands exactly on silence cycle 64: no timeout, period 64 reported.
    wave(0, 1, 63, 64, 1, 63, 1, 0);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 3);
    check_val("d0_timeout_count_final", 32'(to_cnt[0]), 32'd3);
    check_val("d0_mv_count_final", 32'(mv_cnt[0]), 32'd16);
    check_val("all_expectations_consumed", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
